// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage
//   Registered decode/control stage sitting between IF/ID and EX. One 32-bit
//   RV-style instruction is decoded per cycle into EX/MEM/WB control bundles,
//   a sign-extended immediate and register indices, all held in an output
//   register behind a valid/ready handshake. Includes a load-use interlock
//   (one bubble) and a flush input for resolved taken branches/jumps.
//
// Ports
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   upstream handshake, instr is the instruction word
//   flush                 kill held bundle and the incoming instruction
//   out_valid / out_ready downstream handshake
//   ex_ctrl               {ALUSrc, ALU_OP[3:0], RegDst}
//   mem_ctrl              {Branch[1:0], Jump, MemWrite}; Branch 11 = none
//   wb_ctrl               {MemtoReg, RegWrite}
//   jalr                  jump target is rs1+imm rather than pc+imm
//   imm                   sign-extended immediate, truncated to IMM_W
//   rs1, rs2, rd          register indices, 0 when unused
//   illegal               unsupported opcode or branch funct3
module decode_ctrl_stage #(
  parameter int unsigned IMM_W     = 32,
  parameter bit          HAZARD_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       ex_ctrl,
  output logic [3:0]       mem_ctrl,
  output logic [1:0]       wb_ctrl,
  output logic             jalr,
  output logic [IMM_W-1:0] imm,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic             illegal
);

  typedef enum logic [4:0] {
    OP_LOAD   = 5'b00000,
    OP_STORE  = 5'b01000,
    OP_OPIMM  = 5'b00100,
    OP_OP     = 5'b01100,
    OP_BRANCH = 5'b11000,
    OP_JAL    = 5'b11011,
    OP_JALR   = 5'b11001,
    OP_LUI    = 5'b01101
  } opcode_e;

  localparam logic [3:0] MEM_IDLE = 4'b1100;

  // Instruction bits [1:0] carry no information for this decoder.
  logic unused_instr_lsbs;
  assign unused_instr_lsbs = ^instr[1:0];

  // ---------------- combinational decode of the incoming word ----------------
  opcode_e     op;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic [5:0]  dec_ex;
  logic [3:0]  dec_mem;
  logic [1:0]  dec_wb;
  logic        dec_jalr;
  logic [31:0] dec_imm;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_illegal;

  assign op    = opcode_e'(instr[6:2]);
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};

  always_comb begin
    dec_ex      = '0;
    dec_mem     = MEM_IDLE;
    dec_wb      = '0;
    dec_jalr    = 1'b0;
    dec_imm     = '0;
    dec_rs1     = '0;
    dec_rs2     = '0;
    dec_rd      = '0;
    dec_illegal = 1'b0;
    case (op)
      OP_LOAD: begin
        dec_ex  = 6'b100001;
        dec_wb  = 2'b11;
        dec_imm = imm_i;
        dec_rs1 = instr[19:15];
        dec_rd  = instr[11:7];
      end
      OP_STORE: begin
        dec_ex  = 6'b100000;
        dec_mem = 4'b1101;
        dec_imm = imm_s;
        dec_rs1 = instr[19:15];
        dec_rs2 = instr[24:20];
      end
      OP_OPIMM: begin
        dec_ex  = 6'b100001;
        dec_wb  = 2'b01;
        dec_imm = imm_i;
        dec_rs1 = instr[19:15];
        dec_rd  = instr[11:7];
      end
      OP_OP: begin
        dec_ex  = {1'b0, instr[30], instr[14:12], 1'b1};
        dec_wb  = 2'b01;
        dec_rs1 = instr[19:15];
        dec_rs2 = instr[24:20];
        dec_rd  = instr[11:7];
      end
      OP_BRANCH: begin
        // Only BEQ/BNE/BLT are supported; {f3[2], f3[0]} maps them to 00/01/10.
        if (instr[14:12] == 3'b000 || instr[14:12] == 3'b001 || instr[14:12] == 3'b100) begin
          dec_ex  = 6'b010001;
          dec_mem = {instr[14], instr[12], 2'b00};
          dec_imm = imm_b;
          dec_rs1 = instr[19:15];
          dec_rs2 = instr[24:20];
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OP_JAL: begin
        dec_ex  = 6'b100001;
        dec_mem = 4'b1110;
        dec_wb  = 2'b01;
        dec_imm = imm_j;
        dec_rd  = instr[11:7];
      end
      OP_JALR: begin
        dec_ex   = 6'b100001;
        dec_mem  = 4'b1110;
        dec_wb   = 2'b01;
        dec_jalr = 1'b1;
        dec_imm  = imm_i;
        dec_rs1  = instr[19:15];
        dec_rd   = instr[11:7];
      end
      OP_LUI: begin
        dec_ex  = 6'b100001;
        dec_wb  = 2'b01;
        dec_imm = imm_u;
        dec_rd  = instr[11:7];
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // ---------------- output register and handshake ----------------
  logic             out_valid_q, out_valid_d;
  logic [5:0]       ex_ctrl_q, ex_ctrl_d;
  logic [3:0]       mem_ctrl_q, mem_ctrl_d;
  logic [1:0]       wb_ctrl_q, wb_ctrl_d;
  logic             jalr_q, jalr_d;
  logic [IMM_W-1:0] imm_q, imm_d;
  logic [4:0]       rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic             illegal_q, illegal_d;
  logic             held_load;
  logic             hazard;

  // wb_ctrl == 11 (MemtoReg & RegWrite) identifies a held load. Unused source
  // indices decode to 0 and rd_q != 0 is required, so x0 never interlocks.
  assign held_load = out_valid_q && (wb_ctrl_q == 2'b11);
  assign hazard    = HAZARD_EN && held_load && in_valid && (rd_q != '0) &&
                     ((dec_rs1 == rd_q) || (dec_rs2 == rd_q));
  assign in_ready  = (!out_valid_q || out_ready) && !hazard;

  always_comb begin
    // Default is a bubble: reset-valued controls, nothing valid.
    out_valid_d = 1'b0;
    ex_ctrl_d   = '0;
    mem_ctrl_d  = MEM_IDLE;
    wb_ctrl_d   = '0;
    jalr_d      = 1'b0;
    imm_d       = '0;
    rs1_d       = '0;
    rs2_d       = '0;
    rd_d        = '0;
    illegal_d   = 1'b0;
    if (flush) begin
      // bubble
    end else if (out_valid_q && !out_ready) begin
      out_valid_d = 1'b1;
      ex_ctrl_d   = ex_ctrl_q;
      mem_ctrl_d  = mem_ctrl_q;
      wb_ctrl_d   = wb_ctrl_q;
      jalr_d      = jalr_q;
      imm_d       = imm_q;
      rs1_d       = rs1_q;
      rs2_d       = rs2_q;
      rd_d        = rd_q;
      illegal_d   = illegal_q;
    end else if (in_valid && !hazard) begin
      out_valid_d = 1'b1;
      ex_ctrl_d   = dec_ex;
      mem_ctrl_d  = dec_mem;
      wb_ctrl_d   = dec_wb;
      jalr_d      = dec_jalr;
      imm_d       = dec_imm[IMM_W-1:0];
      rs1_d       = dec_rs1;
      rs2_d       = dec_rs2;
      rd_d        = dec_rd;
      illegal_d   = dec_illegal;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      ex_ctrl_q   <= '0;
      mem_ctrl_q  <= MEM_IDLE;
      wb_ctrl_q   <= '0;
      jalr_q      <= 1'b0;
      imm_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      ex_ctrl_q   <= ex_ctrl_d;
      mem_ctrl_q  <= mem_ctrl_d;
      wb_ctrl_q   <= wb_ctrl_d;
      jalr_q      <= jalr_d;
      imm_q       <= imm_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign ex_ctrl   = ex_ctrl_q;
  assign mem_ctrl  = mem_ctrl_q;
  assign wb_ctrl   = wb_ctrl_q;
  assign jalr      = jalr_q;
  assign imm       = imm_q;
  assign rs1       = rs1_q;
  assign rs2       = rs2_q;
  assign rd        = rd_q;
  assign illegal   = illegal_q;

endmodule
